// File: rtl/qpsk_pkg.sv
// Shared constants and types for the QPSK modulator datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qpsk_pkg;

  // Carrier samples per symbol; the cosine/sine generator tables have this length.
  localparam int SPS_DEFAULT = 52;

  // Symbol synchronizer control state.
  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } sync_state_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bit_fifo.sv
// Single-bit FIFO with a pair-wide read port: pushes one bit, pops the two oldest bits at once.
// Latency: a pushed bit is visible on the pair port the cycle after the push edge.
// Backpressure: none internally; the caller gates push on count < DEPTH and pop on count >= 2.
module bit_fifo
  import qpsk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic                              push_bit,
  input  logic                              pop_pair,
  output logic                              pair_first,
  output logic                              pair_second,
  output logic [count_width(DEPTH)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_plus1;
  logic [CNT_W-1:0] push_amt;
  logic [CNT_W-1:0] pop_amt;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign rd_ptr_plus1 = rd_ptr + PTR_W'(1);
  assign pair_first   = mem[rd_ptr];
  assign pair_second  = mem[rd_ptr_plus1];

  assign push_amt = push ? CNT_W'(1) : CNT_W'(0);
  assign pop_amt  = pop_pair ? CNT_W'(2) : CNT_W'(0);

  // Pointer and occupancy tracking; a simultaneous push and pair-pop nets count + 1 - 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_pair) begin
        rd_ptr <= rd_ptr + PTR_W'(2);
      end
      count <= count + push_amt - pop_amt;
    end
  end

  // Storage is not cleared on reset; emptiness is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_bit;
    end
  end

endmodule

// File: rtl/qpsk_symbol_sync.sv
// Splits a serial bit stream into (I,Q) pairs and holds each pair for SPS carrier samples.
// Latency: bits accepted at edges t0,t1 start a symbol (next1, sym_start, data_i/q) at edge t1+1.
// Backpressure: bit_ready = buffered count < FIFO_DEPTH; a pop frees space one cycle later.
module qpsk_symbol_sync
  import qpsk_pkg::*;
#(
  parameter int SPS        = SPS_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic tx_en,
  output logic data_i,
  output logic data_q,
  output logic next1,
  output logic next2,
  output logic sym_start,
  output logic underflow
);

  localparam int CNT_W  = count_width(FIFO_DEPTH);
  localparam int SCNT_W = $clog2(SPS);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SPS - 1);

  sync_state_t       state;
  sync_state_t       state_nxt;
  logic [SCNT_W-1:0] scnt;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              have_pair;
  logic              sym_last;
  logic              underflow_set;
  logic              pair_first;
  logic              pair_second;

  // Decisions use the registered count, so a bit pushed on a symbol's last edge
  // cannot be popped on that same edge.
  assign bit_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push      = bit_valid & bit_ready;
  assign have_pair = (count >= CNT_W'(2));
  assign sym_last  = (scnt == SCNT_LAST);

  bit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_bit    (bit_in),
    .pop_pair    (pop),
    .pair_first  (pair_first),
    .pair_second (pair_second),
    .count       (count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start when enabled with a pair buffered, leave PLAY only at a symbol boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (next2 && have_pair) begin
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (sym_last && !(next2 && have_pair)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pair pop, underflow event and the symbol-active indication.
  always_comb begin
    pop           = 1'b0;
    underflow_set = 1'b0;
    next1         = (state == PLAY);
    case (state)
      IDLE: begin
        pop = next2 && have_pair;
      end
      PLAY: begin
        if (sym_last) begin
          pop = next2 && have_pair;
          // Still enabled but out of bits: the stream broke mid-burst.
          underflow_set = next2 && !have_pair;
        end
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // Sample counter: held at 0 outside PLAY and restarted on every pair pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt <= '0;
    end else if (pop || state_nxt == IDLE) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + SCNT_W'(1);
    end
  end

  // Registered generator-facing outputs; data holds its last pair while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_i    <= 1'b0;
      data_q    <= 1'b0;
      next2     <= 1'b0;
      sym_start <= 1'b0;
      underflow <= 1'b0;
    end else begin
      next2     <= tx_en;
      sym_start <= pop;
      if (pop) begin
        data_i <= pair_first;
        data_q <= pair_second;
      end
      if (underflow_set) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_sync.sv
// Self-checking bench for qpsk_symbol_sync: directed vectors, corner sequences, random traffic.
// Latency: n/a.
// Backpressure: the source holds bit_valid until bit_ready is seen.
module tb_qpsk_symbol_sync;

  localparam int SPS   = 52;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic tx_en;
  logic data_i;
  logic data_q;
  logic next1;
  logic next2;
  logic sym_start;
  logic underflow;

  int checks = 0;
  int errors = 0;

  qpsk_symbol_sync #(
    .SPS        (SPS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .tx_en     (tx_en),
    .data_i    (data_i),
    .data_q    (data_q),
    .next1     (next1),
    .next2     (next2),
    .sym_start (sym_start),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A symbol is "on" for SPS cycles; bits sit in a queue; pairs leave from the front.
  bit mq[$];
  bit m_on, m_tx, m_i, m_q, m_start, m_uf, m_valid;
  int m_left;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    bit push, take;
    if (reset === 1'b1) begin
      mq.delete();
      m_on = 0; m_left = 0; m_tx = 0; m_i = 0; m_q = 0;
      m_start = 0; m_uf = 0; m_valid = 1;
    end else if (m_valid) begin
      push = (bit_valid === 1'b1) && (mq.size() < DEPTH);
      take = 0;
      if (!m_on || m_left == 1) begin
        // Symbol boundary (or idle): only bits buffered before this edge count.
        take = m_tx && (mq.size() >= 2);
        if (m_on && !take) begin
          m_on = 0;
          if (m_tx) m_uf = 1;
        end
      end else begin
        m_left--;
      end
      if (take) begin
        m_i = mq.pop_front();
        m_q = mq.pop_front();
        m_on = 1;
        m_left = SPS;
      end
      m_start = take;
      if (push) mq.push_back(bit_in);
      m_tx = tx_en;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model", {25'd0, next1, next2, sym_start, data_i, data_q, underflow, bit_ready},
            {25'd0, m_on, m_tx, m_start, m_i, m_q, m_uf, (mq.size() < DEPTH)});
    end
  end

  // ---------------- symbol log ----------------
  int   cyc = 0;
  int   st_cyc[$];
  bit   st_i[$];
  bit   st_q[$];
  int   n1_falls = 0;
  logic n1_prev;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sym_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_i.push_back(data_i);
      st_q.push_back(data_q);
    end
    if (n1_prev === 1'b1 && next1 === 1'b0) n1_falls++;
    n1_prev = next1;
  end

  task automatic clear_log();
    st_cyc.delete();
    st_i.delete();
    st_q.delete();
    n1_falls = 0;
  endtask

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; bit_valid = 1'b0; tx_en = 1'b0; bit_in = 1'b0;
    step(1);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic push_bit(input logic b);
    int w = 0;
    bit_in = b;
    bit_valid = 1'b1;
    while (bit_ready !== 1'b1 && w < 300) begin
      step(1);
      w++;
    end
    if (w >= 300) check("push_timeout", bit_ready, 1);
    step(1);
    bit_valid = 1'b0;
  endtask

  // Counts negedges with next1 high, starting from an already-known symbol position.
  task automatic count_play(input int start, output int n);
    n = start;
    while (next1 === 1'b1 && n < 300) begin
      n++;
      step(1);
    end
  endtask

  typedef struct {
    logic rst, tx, vld, b;
    logic n1, ss, di, dq, rdy, uf, n2;
  } vec_t;

  vec_t tv[5];
  int   n;
  int   pct;

  initial begin
    reset = 1'b1; tx_en = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    //              rst tx vld b   n1 ss di dq rdy uf n2
    tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    step(1);

    // Single symbol: reset state, two-push latency, then the one-shot symbol runs out.
    for (int k = 0; k < 5; k++) begin
      reset = tv[k].rst; tx_en = tv[k].tx; bit_valid = tv[k].vld; bit_in = tv[k].b;
      step(1);
      check($sformatf("vec%0d_next1", k), next1, tv[k].n1);
      check($sformatf("vec%0d_sym_start", k), sym_start, tv[k].ss);
      check($sformatf("vec%0d_data_i", k), data_i, tv[k].di);
      check($sformatf("vec%0d_data_q", k), data_q, tv[k].dq);
      check($sformatf("vec%0d_bit_ready", k), bit_ready, tv[k].rdy);
      check($sformatf("vec%0d_underflow", k), underflow, tv[k].uf);
      check($sformatf("vec%0d_next2", k), next2, tv[k].n2);
    end
    step(SPS - 2);
    check("single_last_cycle_next1", next1, 1);
    check("single_last_cycle_uf", underflow, 0);
    step(1);
    check("single_end_next1", next1, 0);
    check("single_end_uf", underflow, 1);

    // Continuous stream: three seamless symbols.
    do_reset();
    tx_en = 1'b1;
    push_bit(1); push_bit(1); push_bit(0); push_bit(0); push_bit(1); push_bit(0);
    step(3 * SPS + 10);
    check("stream_nsym", st_cyc.size(), 3);
    if (st_cyc.size() == 3) begin
      check("stream_gap1", st_cyc[1] - st_cyc[0], SPS);
      check("stream_gap2", st_cyc[2] - st_cyc[1], SPS);
      check("stream_pairs", {st_i[0], st_q[0], st_i[1], st_q[1], st_i[2], st_q[2]}, 6'b110010);
    end
    check("stream_next1_falls", n1_falls, 1);

    // Backpressure: full FIFO holds the fifth bit until a pop frees space.
    do_reset();
    push_bit(1); push_bit(0); push_bit(1); push_bit(1);
    check("bp_ready_full", bit_ready, 0);
    bit_in = 1'b0; bit_valid = 1'b1;
    step(3);
    check("bp_ready_held", bit_ready, 0);
    tx_en = 1'b1;
    step(1);
    check("bp_next2", next2, 1);
    check("bp_ready_before_pop", bit_ready, 0);
    step(1);
    check("bp_start", {sym_start, next1, data_i, data_q}, 4'b1110);
    check("bp_ready_after_pop", bit_ready, 1);
    step(1);
    bit_valid = 1'b0;
    step(2 * SPS + 5);

    // tx_en drop mid-symbol: finish the count, keep buffered bits, no underflow.
    do_reset();
    push_bit(1); push_bit(0); push_bit(0); push_bit(1);
    tx_en = 1'b1;
    step(2);
    check("drop_start", sym_start, 1);
    step(20);
    tx_en = 1'b0;
    step(1);
    check("drop_next2", next2, 0);
    check("drop_next1", next1, 1);
    count_play(21, n);
    check("drop_sym_len", n, SPS);
    check("drop_uf", underflow, 0);
    check("drop_ready", bit_ready, 1);
    tx_en = 1'b1;
    step(2);
    check("drop_resume", {sym_start, data_i, data_q}, 3'b101);

    // Reset mid-symbol, then a fresh pair restarts from sample 0.
    do_reset();
    tx_en = 1'b1;
    push_bit(1); push_bit(1);
    step(1);
    check("rst_first_start", sym_start, 1);
    step(30);
    reset = 1'b1;
    step(1);
    check("rst_outputs", {data_i, data_q, next1, next2, sym_start, underflow, bit_ready}, 7'b0000001);
    reset = 1'b0;
    clear_log();
    push_bit(0); push_bit(1);
    step(1);
    check("rst_restart", {sym_start, data_i, data_q}, 3'b101);
    count_play(0, n);
    check("rst_restart_len", n, SPS);

    // Last-cycle push with one bit buffered: underflow, then restart from IDLE.
    do_reset();
    push_bit(1); push_bit(0); push_bit(1);
    tx_en = 1'b1;
    step(2);
    check("lcp_start", sym_start, 1);
    step(SPS - 1);
    bit_in = 1'b0; bit_valid = 1'b1;
    step(1);
    bit_valid = 1'b0;
    check("lcp_idle", {next1, underflow, sym_start}, 3'b010);
    step(1);
    check("lcp_restart", {sym_start, next1, data_i, data_q}, 4'b1110);

    // Random traffic checked cycle by cycle against the model.
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      pct = (seg % 4 == 0) ? 30 : (seg % 4 == 1) ? 60 : (seg % 4 == 2) ? 90 : 100;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 99) < 2) tx_en = ~tx_en;
        bit_valid = ($urandom_range(0, 99) < pct);
        bit_in = $urandom_range(0, 1);
        reset = ($urandom_range(0, 999) == 0);
        step(1);
      end
    end
    reset = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
